// File: rtl/matmul_engine_nxn_if.sv
// Stream bundle for matmul_engine_nxn: A/B element input, job
// controls, C element output and job status.
interface matmul_engine_nxn_if #(
    parameter int DW   = 8,
    parameter int ACCW = 17
);
    logic signed [DW-1:0]   in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   keep_b;
    logic                   transpose;
    logic                   relu;
    logic signed [ACCW-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   done;
    logic [1:0]             state;

    modport master (
        output in_data, in_valid, keep_b, transpose, relu, out_ready,
        input  in_ready, out_data, out_valid, done, state
    );

    modport slave (
        input  in_data, in_valid, keep_b, transpose, relu, out_ready,
        output in_ready, out_data, out_valid, done, state
    );
endinterface

// File: rtl/matmul_engine_nxn.sv
// N x N signed matrix multiply on an output-stationary systolic array.
// Optional ReLU clamp on results is built only when TPU_RELU_EN is defined.
module matmul_engine_nxn #(
    parameter int N    = 2,
    parameter int DW   = 8,
    parameter int ACCW = 2*DW + $clog2(N)
) (
    input logic                clk,
    input logic                rst,
    matmul_engine_nxn_if.slave bus
);
    localparam int IW       = $clog2(N);
    localparam int CW       = $clog2(3*N);
    localparam int LAST_CYC = 3*N - 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          done_q;
    logic          keep_q;
    logic          tr_q;
    logic          ld_sel;
    logic [IW-1:0] ld_r;
    logic [IW-1:0] ld_c;
    logic [CW-1:0] cyc;
    logic [IW-1:0] o_r;
    logic [IW-1:0] o_c;
`ifdef TPU_RELU_EN
    logic          relu_q;
`endif

    logic signed [DW-1:0]   a_mem  [N][N];
    logic signed [DW-1:0]   b_mem  [N][N];
    logic signed [DW-1:0]   a_pipe [N][N];
    logic signed [DW-1:0]   b_pipe [N][N];
    logic signed [ACCW-1:0] acc    [N][N];

    logic signed [DW-1:0]   feed_a [N];
    logic signed [DW-1:0]   feed_b [N];
    logic signed [DW-1:0]   a_in   [N][N];
    logic signed [DW-1:0]   b_in   [N][N];
    logic signed [2*DW-1:0] prod   [N][N];
    logic signed [ACCW-1:0] c_sel;
    logic signed [ACCW-1:0] c_out;

    logic in_fire;
    logic out_fire;
    logic col_last;
    logic row_last;
    logic ld_last;
    logic oc_last;
    logic or_last;

    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;
    assign col_last = (ld_c == IW'(N-1));
    assign row_last = (ld_r == IW'(N-1));
    assign ld_last  = col_last && row_last && (ld_sel || keep_q);
    assign oc_last  = (o_c == IW'(N-1));
    assign or_last  = (o_r == IW'(N-1));

    // Job FSM, element loader and operand storage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            keep_q      <= 1'b0;
            tr_q        <= 1'b0;
            ld_sel      <= 1'b0;
            ld_r        <= '0;
            ld_c        <= '0;
            cyc         <= '0;
            o_r         <= '0;
            o_c         <= '0;
`ifdef TPU_RELU_EN
            relu_q      <= 1'b0;
`endif
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_mem[i][j] <= '0;
                    b_mem[i][j] <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_fire) begin
                        a_mem[0][0] <= bus.in_data;
                        keep_q      <= bus.keep_b;
                        ld_sel      <= 1'b0;
                        ld_r        <= '0;
                        ld_c        <= IW'(1);
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_fire) begin
                        for (int i = 0; i < N; i++) begin
                            for (int j = 0; j < N; j++) begin
                                if (int'(ld_r) == i && int'(ld_c) == j) begin
                                    if (ld_sel) b_mem[i][j] <= bus.in_data;
                                    else        a_mem[i][j] <= bus.in_data;
                                end
                            end
                        end
                        if (col_last) begin
                            ld_c <= '0;
                            if (row_last) begin
                                ld_r   <= '0;
                                ld_sel <= 1'b1;
                            end else begin
                                ld_r <= ld_r + 1'b1;
                            end
                        end else begin
                            ld_c <= ld_c + 1'b1;
                        end
                        if (ld_last) begin
                            state_q    <= S_COMPUTE;
                            in_ready_q <= 1'b0;
                            cyc        <= '0;
                            tr_q       <= bus.transpose;
`ifdef TPU_RELU_EN
                            relu_q     <= bus.relu;
`endif
                        end
                    end
                end
                S_COMPUTE: begin
                    cyc <= cyc + 1'b1;
                    if (int'(cyc) == LAST_CYC) begin
                        state_q     <= S_OUTPUT;
                        out_valid_q <= 1'b1;
                        o_r         <= '0;
                        o_c         <= '0;
                    end
                end
                S_OUTPUT: begin
                    if (out_fire) begin
                        if (oc_last) begin
                            o_c <= '0;
                            if (or_last) begin
                                o_r         <= '0;
                                state_q     <= S_IDLE;
                                out_valid_q <= 1'b0;
                                in_ready_q  <= 1'b1;
                                done_q      <= 1'b1;
                            end else begin
                                o_r <= o_r + 1'b1;
                            end
                        end else begin
                            o_c <= o_c + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Skewed edge feeds: row i / column j see operand k at cycle i+k / j+k
    always_comb begin
        for (int i = 0; i < N; i++) begin
            feed_a[i] = '0;
            feed_b[i] = '0;
            for (int k = 0; k < N; k++) begin
                if (int'(cyc) == i + k) begin
                    feed_a[i] = a_mem[i][k];
                    feed_b[i] = tr_q ? b_mem[i][k] : b_mem[k][i];
                end
            end
        end
    end

    // PE operand routing: A moves right, B moves down, one PE per cycle
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = feed_a[i];
            b_in[0][i] = feed_b[i];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 1; j < N; j++) begin
                a_in[i][j] = a_pipe[i][j-1];
                b_in[j][i] = b_pipe[j-1][i];
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod[i][j] = a_in[i][j] * b_in[i][j];
            end
        end
    end

    // Systolic array: cleared while loading, accumulates during compute
    always_ff @(posedge clk) begin
        if (rst || state_q == S_LOAD) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_pipe[i][j] <= '0;
                    b_pipe[i][j] <= '0;
                    acc[i][j]    <= '0;
                end
            end
        end else if (state_q == S_COMPUTE) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    a_pipe[i][j] <= a_in[i][j];
                    b_pipe[i][j] <= b_in[i][j];
                    acc[i][j]    <= acc[i][j] + ACCW'(prod[i][j]);
                end
            end
        end
    end

    // Row-major result select
    always_comb begin
        c_sel = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (int'(o_r) == i && int'(o_c) == j) c_sel = acc[i][j];
            end
        end
    end

`ifdef TPU_RELU_EN
    assign c_out = (relu_q && c_sel[ACCW-1]) ? '0 : c_sel;
`else
    logic unused_relu;
    assign unused_relu = bus.relu;
    assign c_out       = c_sel;
`endif

    assign bus.out_data  = out_valid_q ? c_out : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.done      = done_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_matmul_engine_nxn.sv
// Directed checks for matmul_engine_nxn on N=2 and N=4 instances,
// including ReLU expectations that follow TPU_RELU_EN.
`timescale 1ns/1ps
module tb_matmul_engine_nxn;
    localparam int DW = 8;
    localparam int A2 = 2*DW + 1;
    localparam int A4 = 2*DW + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int v2[8];
    int e2[4];
    int r2[4];
    int lat2;
    int to2;
    int ma[4][4];
    int mb[4][4];
    int mc[4][4];

    always #5 clk = ~clk;

    matmul_engine_nxn_if #(.DW(DW), .ACCW(A2)) b2();
    matmul_engine_nxn_if #(.DW(DW), .ACCW(A4)) b4();

    matmul_engine_nxn #(.N(2), .DW(DW)) u2 (
        .clk(clk),
        .rst(rst),
        .bus(b2)
    );

    matmul_engine_nxn #(.N(4), .DW(DW)) u4 (
        .clk(clk),
        .rst(rst),
        .bus(b4)
    );

    task automatic drive2(input int cnt, input logic kb, input logic tr, input logic rl);
        b2.keep_b    = kb;
        b2.transpose = tr;
        b2.relu      = rl;
        for (int e = 0; e < cnt; e++) begin
            b2.in_data  = DW'(v2[e]);
            b2.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        b2.in_valid = 1'b0;
    endtask

    task automatic collect2();
        int w;
        lat2 = 1;
        to2  = 0;
        b2.out_ready = 1'b1;
        while (!b2.out_valid && lat2 < 40) begin
            @(negedge clk);
            lat2++;
        end
        for (int n = 0; n < 4; n++) begin
            w = 0;
            while (!b2.out_valid && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (!b2.out_valid) to2++;
            r2[n] = int'(b2.out_data);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load4(input logic gaps, input logic tr, input logic rl);
        int val;
        b4.keep_b    = 1'b0;
        b4.transpose = tr;
        b4.relu      = rl;
        for (int e = 0; e < 32; e++) begin
            val = (e < 16) ? ma[e/4][e%4] : mb[(e-16)/4][(e-16)%4];
            while (gaps && $urandom_range(0, 2) == 0) begin
                b4.in_valid = 1'b0;
                @(negedge clk);
            end
            b4.in_data  = DW'(val);
            b4.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        b4.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (b2.state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", b2.state);
        end
        checks++;
        if (b2.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", b2.in_ready);
        end
        checks++;
        if (b2.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", b2.out_valid);
        end
        checks++;
        if (b2.out_data !== '0) begin
            errors++;
            $display("FAIL reset_out_data: got %0d expected 0", b2.out_data);
        end
        checks++;
        if (b2.done !== 1'b0 || b4.state !== 2'd0) begin
            errors++;
            $display("FAIL reset_done: got done=%b st4=%0d expected 0 0", b2.done, b4.state);
        end
    endtask

    task automatic test_basic();
        v2 = '{1, 2, 3, 4, 5, 6, 7, 8};
        e2 = '{19, 22, 43, 50};
        drive2(8, 1'b0, 1'b0, 1'b0);
        collect2();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (r2[n] !== e2[n]) begin
                errors++;
                $display("FAIL basic[%0d]: got %0d expected %0d", n, r2[n], e2[n]);
            end
        end
        checks++;
        if (lat2 !== 5) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 5", lat2);
        end
        checks++;
        if (to2 !== 0) begin
            errors++;
            $display("FAIL basic_timeout: got %0d expected 0", to2);
        end
        checks++;
        if (b2.done !== 1'b1 || b2.state !== 2'd0 || b2.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: got done=%b st=%0d rdy=%b expected 1 0 1",
                     b2.done, b2.state, b2.in_ready);
        end
        @(negedge clk);
        checks++;
        if (b2.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: got %b expected 0", b2.done);
        end
    endtask

    task automatic test_transpose();
        v2 = '{1, 2, 3, 4, 5, 6, 7, 8};
        e2 = '{17, 23, 39, 53};
        drive2(8, 1'b0, 1'b1, 1'b0);
        collect2();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (r2[n] !== e2[n]) begin
                errors++;
                $display("FAIL transpose[%0d]: got %0d expected %0d", n, r2[n], e2[n]);
            end
        end
        checks++;
        if (to2 !== 0) begin
            errors++;
            $display("FAIL transpose_timeout: got %0d expected 0", to2);
        end
    endtask

    task automatic test_relu();
        v2 = '{-1, 0, 0, 1, 5, 6, 7, 8};
`ifdef TPU_RELU_EN
        e2 = '{0, 0, 7, 8};
`else
        e2 = '{-5, -6, 7, 8};
`endif
        drive2(8, 1'b0, 1'b0, 1'b1);
        collect2();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (r2[n] !== e2[n]) begin
                errors++;
                $display("FAIL relu[%0d]: got %0d expected %0d", n, r2[n], e2[n]);
            end
        end
    endtask

    task automatic test_keep_b();
        v2 = '{1, 0, 0, 1, 0, 0, 0, 0};
        e2 = '{5, 6, 7, 8};
        drive2(4, 1'b1, 1'b0, 1'b0);
        collect2();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (r2[n] !== e2[n]) begin
                errors++;
                $display("FAIL keep_b[%0d]: got %0d expected %0d", n, r2[n], e2[n]);
            end
        end
        do_reset();
        drive2(4, 1'b1, 1'b0, 1'b0);
        collect2();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (r2[n] !== 0) begin
                errors++;
                $display("FAIL keep_b_after_rst[%0d]: got %0d expected 0", n, r2[n]);
            end
        end
    endtask

    task automatic test_extremes();
        v2 = '{-128, -128, -128, -128, -128, -128, -128, -128};
        drive2(8, 1'b0, 1'b0, 1'b0);
        collect2();
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (r2[n] !== 32768) begin
                errors++;
                $display("FAIL extremes[%0d]: got %0d expected 32768", n, r2[n]);
            end
        end
    endtask

    task automatic test_random4();
        logic tr;
        logic rl;
        logic stall;
        int   held;
        int   n;
        int   guard;
        for (int job = 0; job < 3; job++) begin
            tr = 1'($urandom_range(0, 1));
            rl = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    ma[i][j] = int'($urandom_range(0, 255)) - 128;
                    mb[i][j] = int'($urandom_range(0, 255)) - 128;
                end
            end
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    mc[i][j] = 0;
                    for (int k = 0; k < 4; k++) begin
                        mc[i][j] += ma[i][k] * (tr ? mb[j][k] : mb[k][j]);
                    end
`ifdef TPU_RELU_EN
                    if (rl && mc[i][j] < 0) mc[i][j] = 0;
`endif
                end
            end
            load4(1'b1, tr, rl);
            n     = 0;
            guard = 0;
            stall = 1'b0;
            held  = 0;
            while (n < 16 && guard < 2000) begin
                if (b4.out_valid) begin
                    if (stall) begin
                        checks++;
                        if (int'(b4.out_data) !== held) begin
                            errors++;
                            $display("FAIL rand_hold[%0d]: got %0d expected %0d",
                                     n, int'(b4.out_data), held);
                        end
                    end
                    b4.out_ready = 1'($urandom_range(0, 1));
                    held  = int'(b4.out_data);
                    stall = !b4.out_ready;
                    if (b4.out_ready) begin
                        checks++;
                        if (held !== mc[n/4][n%4]) begin
                            errors++;
                            $display("FAIL rand_job%0d[%0d]: got %0d expected %0d",
                                     job, n, held, mc[n/4][n%4]);
                        end
                        n++;
                    end
                end else begin
                    b4.out_ready = 1'($urandom_range(0, 1));
                    stall = 1'b0;
                end
                @(negedge clk);
                guard++;
            end
            b4.out_ready = 1'b0;
            checks++;
            if (n !== 16) begin
                errors++;
                $display("FAIL rand_timeout: got %0d outputs expected 16", n);
            end
            checks++;
            if (b4.done !== 1'b1) begin
                errors++;
                $display("FAIL rand_done: got %b expected 1", b4.done);
            end
        end
    endtask

    task automatic test_abort();
        int   w;
        logic seen;
        load4(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (b4.state !== 2'd2) begin
            errors++;
            $display("FAIL abort_in_compute: got state %0d expected 2", b4.state);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (b4.state !== 2'd0 || b4.out_valid !== 1'b0 || b4.done !== 1'b0
            || b4.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_compute: got st=%0d ov=%b done=%b rdy=%b expected 0 0 0 1",
                     b4.state, b4.out_valid, b4.done, b4.in_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (b4.done || b4.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_compute_quiet: got activity %b expected 0", seen);
        end
        load4(1'b0, 1'b0, 1'b0);
        w = 0;
        while (!b4.out_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        b4.out_ready = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (b4.state !== 2'd3 || b4.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_output: got st=%0d ov=%b expected 3 1",
                     b4.state, b4.out_valid);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        b4.out_ready = 1'b0;
        checks++;
        if (b4.state !== 2'd0 || b4.out_valid !== 1'b0 || b4.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_output: got st=%0d ov=%b done=%b expected 0 0 0",
                     b4.state, b4.out_valid, b4.done);
        end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (b4.done) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_output_no_done: got %b expected 0", seen);
        end
    endtask

    initial begin
        b2.in_data   = '0;
        b2.in_valid  = 1'b0;
        b2.keep_b    = 1'b0;
        b2.transpose = 1'b0;
        b2.relu      = 1'b0;
        b2.out_ready = 1'b0;
        b4.in_data   = '0;
        b4.in_valid  = 1'b0;
        b4.keep_b    = 1'b0;
        b4.transpose = 1'b0;
        b4.relu      = 1'b0;
        b4.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_transpose();
        test_relu();
        test_keep_b();
        test_extremes();
        test_random4();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
